rr_reg_mux: RTL and testbench

//   Parametrised, registered N:1 data multiplexer with valid/ready handshake on every port.

---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_reg_mux_if.sv | 39 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/rr_reg_mux.sv | 106 ++++++++++
 tb/tb_rr_reg_mux.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the registered round-robin multiplexer.
package rr_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel index width. Never returns less than one bit, so N=1 or N=2 still yields a usable index.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_reg_mux_if.sv
// Stream bundle between N producers, the multiplexer and a single consumer.
// With RR_MUX_PARITY_EN defined the bundle also carries out_par.
interface rr_reg_mux_if
  import rr_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int CH_W = idx_w(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [CH_W-1:0]    out_ch;
  logic               out_valid;
  logic               out_ready;
`ifdef RR_MUX_PARITY_EN
  logic               out_par;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_par
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_par
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester after ptr, wrapping modulo N.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [idx_w(N)-1:0]  gnt_idx
);
  localparam int CH_W = idx_w(N);

  logic [CH_W-1:0] cand_idx;
  logic            found;

  // ptr itself is scanned last, so the previous winner has lowest priority.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    cand_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = CH_W'((int'(ptr) + k) % N);
      if (en && !found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rr_reg_mux.sv
// Registered N:1 stream multiplexer with fixed-select or round-robin channel choice.
// Define RR_MUX_PARITY_EN to add a registered even-parity bit (out_par) alongside out_data.
module rr_reg_mux
  import rr_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [idx_w(N)-1:0] sel,
  rr_reg_mux_if.slave         bus
);
  localparam int CH_W = idx_w(N);

  logic [N-1:0]     rr_gnt;
  logic [N-1:0]     fix_gnt;
  logic [N-1:0]     gnt;
  logic [CH_W-1:0]  rr_idx;
  logic [CH_W-1:0]  gnt_idx;
  logic             any_gnt;
  logic             load;
  logic [WIDTH-1:0] gnt_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]  out_ch_q,    out_ch_d;
  logic [CH_W-1:0]  ptr_q,       ptr_d;

  rr_arbiter #(.N(N)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .en      (mode == MODE_RR),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // A select value of N or above matches no channel, so it yields no grant.
  for (genvar gi = 0; gi < N; gi++) begin : g_fix
    assign fix_gnt[gi] = bus.in_valid[gi] && (sel == CH_W'(gi));
  end

  always_comb begin
    gnt      = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
    any_gnt  = |gnt;
    load     = !out_valid_q || bus.out_ready;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      gnt_data = gnt_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any_gnt;
      if (any_gnt) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
        ptr_d      = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CH_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  // Nothing is accepted while reset is held, even though the empty register would otherwise load.
  assign bus.in_ready  = (load && rst_n) ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

`ifdef RR_MUX_PARITY_EN
  logic out_par_q, out_par_d;

  assign out_par_d = ^out_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
    end
  end

  assign bus.out_par = out_par_q;
`endif

endmodule

// File: tb/tb_rr_reg_mux.sv
// Directed and randomized checks of rr_reg_mux (N=4, WIDTH=8) against a cycle-level reference model.
module tb_rr_reg_mux;
  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] sel;

  rr_reg_mux_if #(.N(N), .WIDTH(WIDTH)) bus ();

  rr_reg_mux #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the output register should hold and which channel won last.
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_last;

  // Per-channel sequence numbers for the loss/duplication scoreboard.
  bit sb_on = 1'b0;
  int tx_seq[N];
  int rx_seq[N];
  int n_tx, n_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_seq_data();
    for (int i = 0; i < N; i++) begin
      bus.in_data[i*WIDTH +: WIDTH] = 8'((i << 6) | (tx_seq[i] & 63));
    end
  endtask

  // One clock: check combinational ready, advance the model over the edge, check registered outputs.
  task automatic cycle();
    int   g;
    int   c;
    bit   load;
    logic [7:0] cand_data;
    if (sb_on) drive_seq_data();
    #1;
    load = !m_valid || bus.out_ready;
    g    = -1;
    if (mode == 1'b0) begin
      if (bus.in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (g < 0 && bus.in_valid[c]) g = c;
      end
    end
    check("in_ready", 32'(bus.in_ready), (load && g >= 0) ? (32'd1 << g) : 32'd0);
    cand_data = (g >= 0) ? bus.in_data[g*WIDTH +: WIDTH] : 8'h00;
    if (sb_on && bus.out_valid && bus.out_ready) begin
      c = int'(bus.out_ch);
      check("sb_data", 32'(bus.out_data), 32'((c << 6) | (rx_seq[c] & 63)));
      rx_seq[c]++;
      n_rx++;
    end
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = cand_data;
        m_ch    = g;
        m_last  = g;
        if (sb_on) begin
          tx_seq[g]++;
          n_tx++;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_ch", 32'(bus.out_ch), 32'(m_ch));
`ifdef RR_MUX_PARITY_EN
    check("out_par", 32'(bus.out_par), 32'(^m_data));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_last  = N - 1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
`ifdef RR_MUX_PARITY_EN
    check("rst_out_par", 32'(bus.out_par), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] held_data;
  logic [1:0] held_ch;

  initial begin
    rst_n         = 1'b0;
    mode          = 1'b0;
    sel           = 2'd0;
    bus.in_data   = '0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    do_reset();

    // Fixed select of channel 2.
    mode         = 1'b0;
    sel          = 2'd2;
    bus.in_valid = 4'b1111;
    bus.in_data  = 32'h33A5_1100;
    cycle();
    check("fix_data", 32'(bus.out_data), 32'h0000_00A5);
    check("fix_ch", 32'(bus.out_ch), 32'd2);
    check("fix_ready", 32'(bus.in_ready), 32'b0100);

    // Selected channel idle: no grant, register empties, data holds.
    sel          = 2'd3;
    bus.in_valid = 4'b0111;
    cycle();
    check("fix_idle_valid", 32'(bus.out_valid), 32'd0);
    check("fix_idle_data", 32'(bus.out_data), 32'h0000_00A5);

`ifdef RR_MUX_PARITY_EN
    sel          = 2'd0;
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_0007;
    cycle();
    check("par_07", 32'(bus.out_par), 32'd1);
    bus.in_data  = 32'h0000_0003;
    cycle();
    check("par_03", 32'(bus.out_par), 32'd0);
`endif

    // Reset while a beat is held under back-pressure.
    sel           = 2'd1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'h4433_2211;
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    cycle();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    do_reset();

    // Round-robin fairness with every channel valid.
    mode          = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_fair_ch", 32'(bus.out_ch), 32'(k % N));
    end

    // Skipping idle channels.
    bus.in_valid = 4'b0010;
    cycle();
    check("rr_skip_ch1", 32'(bus.out_ch), 32'd1);
    bus.in_valid = 4'b1010;
    cycle();
    check("rr_skip_ch3", 32'(bus.out_ch), 32'd3);
    cycle();
    check("rr_skip_ch1b", 32'(bus.out_ch), 32'd1);

    // Only the top channel valid: it wins every cycle.
    bus.in_valid = 4'b1000;
    cycle();
    cycle();
    check("rr_wrap_ch3", 32'(bus.out_ch), 32'd3);

    // Back-pressure with the scoreboard running.
    do_reset();
    for (int i = 0; i < N; i++) begin
      tx_seq[i] = 0;
      rx_seq[i] = 0;
    end
    n_tx          = 0;
    n_rx          = 0;
    sb_on         = 1'b1;
    mode          = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    cycle();
    held_data     = bus.out_data;
    held_ch       = bus.out_ch;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_data", 32'(bus.out_data), 32'(held_data));
      check("bp_ch", 32'(bus.out_ch), 32'(held_ch));
      check("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;

    // Randomized traffic, mode and select changes any cycle.
    for (int k = 0; k < 400; k++) begin
      mode          = 1'($urandom_range(0, 1));
      sel           = 2'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom % 4) != 0;
      cycle();
    end

    // Drain and confirm every accepted beat came out exactly once.
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    cycle();
    cycle();
    check("sb_count", 32'(n_rx), 32'(n_tx));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
